// File: rtl/hello_world_rx.sv
// UART 8N1 receiver with a streaming "Hello, World!" matcher.
// Each received byte is strobed out on valid; a complete message pulses match.
module hello_world_rx #(
  parameter int CLOCK_RATE     = 5,
  parameter int BAUD_RATE      = 1,
  parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy,
  output logic       match,
  output logic [7:0] match_count
);

  localparam int CNT_W   = $clog2(CLOCKS_PER_BIT);
  localparam int HALF    = CLOCKS_PER_BIT / 2;
  localparam int MSG_LEN = 13;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(MSG_LEN - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    msg_byte = 8'h48; // H
      4'd1:    msg_byte = 8'h65; // e
      4'd2:    msg_byte = 8'h6C; // l
      4'd3:    msg_byte = 8'h6C; // l
      4'd4:    msg_byte = 8'h6F; // o
      4'd5:    msg_byte = 8'h2C; // ,
      4'd6:    msg_byte = 8'h20; // space
      4'd7:    msg_byte = 8'h57; // W
      4'd8:    msg_byte = 8'h6F; // o
      4'd9:    msg_byte = 8'h72; // r
      4'd10:   msg_byte = 8'h6C; // l
      4'd11:   msg_byte = 8'h64; // d
      4'd12:   msg_byte = 8'h21; // !
      default: msg_byte = 8'h00;
    endcase
  endfunction

  // Synchroniser: rx is asynchronous to clk
  logic rx_meta_q, rs_q;

  // NOTE: reset value 1 matches the idle line, so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments give true flop-to-flop behaviour; blocking would collapse the chain.
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
    end
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rs_q;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rs_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Matcher: 'H' appears only at position 0, so a mismatching 'H' restarts at index 1
  logic [3:0] idx_q, idx_d;
  logic       match_q, match_d;
  logic [7:0] mcount_q, mcount_d;

  always_comb begin
    idx_d    = idx_q;
    match_d  = 1'b0;
    mcount_d = mcount_q;
    if (valid_q) begin
      if (data_q == msg_byte(idx_q)) begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          match_d = 1'b1;
          if (mcount_q != 8'hFF) mcount_d = mcount_q + 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else if (data_q == msg_byte(4'd0)) begin
        idx_d = 4'd1;
      end else begin
        idx_d = '0;
      end
    end else if (ferr_q) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      match_q  <= 1'b0;
      mcount_q <= '0;
    end else begin
      idx_q    <= idx_d;
      match_q  <= match_d;
      mcount_q <= mcount_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != S_IDLE);
  assign match         = match_q;
  assign match_count   = mcount_q;

endmodule

// File: doc/hello_world_rx.md
Name: hello_world_rx

Overview:
- Receive end of the serial "Hello, World!" link: a UART 8N1 receiver plus a streaming string matcher.
- Deserialises bytes from the line, presents each byte with a one-cycle valid strobe, and flags every complete occurrence of the 13-byte message "Hello, World!".
- Sits on the board-side rx pin.
- Used as the loopback checker for the serial transmit path.

Parameters:
- CLOCK_RATE, 5, system clock frequency in Hz (board value 100_000_000).
- BAUD_RATE, 1, line rate in baud (board value 115_200).
- CLOCKS_PER_BIT, CLOCK_RATE / BAUD_RATE, clock cycles per bit; must be >= 4.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last received byte; held until the next valid byte.
- valid  output  1  one-cycle strobe; data holds a new byte.
- framing_error  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high while a frame is in progress (START through WAIT_IDLE).
- match  output  1  one-cycle strobe; complete "Hello, World!" received.
- match_count  output  8  number of matches, saturating at 255.

Behaviour:
- Reset (rst=0), effective immediately regardless of clk:
  - data=0, valid=0, framing_error=0, busy=0, match=0, match_count=0.
  - Synchroniser=1, FSM=IDLE, match index=0.
  - Mid-frame reset abandons the frame and emits no strobes.
- rx passes through a 2-flop synchroniser, reset value 1. All references to rx below mean the synchronised value rs.
- Let H = CLOCKS_PER_BIT/2 (integer division). A bit counter of clog2(CLOCKS_PER_BIT) bits counts cycles within a bit.
- IDLE:
  - busy=0.
  - rs==0 -> START, counter cleared.
- START:
  - When the counter reaches H-1, sample rs.
  - rs==0 -> DATA, counter cleared, bit index=0.
  - rs==1 -> IDLE, treated as a glitch: no strobes, no error.
- DATA:
  - When the counter reaches CLOCKS_PER_BIT-1, sample rs into shift register bit [bit index]. Data is LSB first.
  - After bit 7 -> STOP.
- STOP:
  - When the counter reaches CLOCKS_PER_BIT-1, sample rs.
  - rs==1: next cycle valid=1 and data=shift register -> IDLE.
  - rs==0: next cycle framing_error=1, data unchanged -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rs==1, then -> IDLE.
  - A held-low line (break) produces exactly one framing_error.
- busy is high in START, DATA, STOP and WAIT_IDLE.
- Matcher: 4-bit index into a 13-entry constant message "Hello, World!" (index 0 = 'H'). Evaluated on the cycle valid=1:
  - byte == message[index] and index==12: match=1 the following cycle, index=0, match_count increments, saturating at 255.
  - byte == message[index] and index<12: index+1.
  - mismatch and byte=='H': index=1. 'H' occurs only at position 0, so this restart is exact.
  - mismatch otherwise: index=0.
  - framing_error: index=0.
- Latency: match is asserted exactly 1 cycle after the valid strobe carrying '!'.
- All strobes are single-cycle and never asserted during reset. valid and framing_error are never both high.
- Back-to-back frames: a start bit is accepted on the first cycle after STOP returns to IDLE. There is no minimum inter-frame gap beyond the stop bit.

Test Plan:
- Drive "Hello, World!" 8N1 with CLOCKS_PER_BIT=5 and no gaps -> 13 valid strobes with data 0x48,0x65,...,0x21 in order; one match strobe 1 cycle after the 0x21 valid; match_count=1; framing_error never high.
- Drive "HeHello, World!" -> 15 valid strobes, exactly one match, match_count=1. Then drive "Hello, World?" -> no further match, match_count stays 1.
- Pulse rx low for 1 cycle (< H) while idle -> busy rises then returns to 0 within H+3 cycles; no valid, no framing_error.
- Send 0x48 with stop bit forced low, then hold rx low for 20 cycles, then release -> exactly one framing_error strobe, no valid, busy stays high until rx is high; a following full message gives match_count=1.
- Assert rst for 1 cycle mid-way through the 7th byte of the message -> all outputs 0 immediately; a subsequent complete message produces exactly one match, match_count=1.
- Loopback: connect the serial transmitter's tx to rx with identical parameters and pulse its trigger -> one match after its busy falls.
